// File: rtl/blob_frame_ctrl.sv
// Frame sequencer for the blob labeler: arms, aligns to SOF and forwards one tagged frame with 1-cycle latency.
// The pixel path has no backpressure; the blob count is held on a valid/ready port until it is taken.
module blob_frame_ctrl #(
   parameter int IMG_COL      = 640,
   parameter int IMG_ROW      = 480,
   parameter int COUNT_W      = 8,
   parameter int DONE_TIMEOUT = 65535
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_start,
   input  logic                       i_continuous,
   input  logic                       i_frame_start,
   input  logic                       i_pix_valid,
   input  logic                       i_pix_bin,
   output logic                       o_blob_valid,
   output logic                       o_blob_seq,
   output logic                       o_blob_clr,
   output logic [$clog2(IMG_COL)-1:0] o_col,
   output logic [$clog2(IMG_ROW)-1:0] o_row,
   output logic                       o_frame_last,
   input  logic                       i_blob_done,
   input  logic [COUNT_W-1:0]         i_blob_count,
   output logic                       o_busy,
   output logic                       o_result_valid,
   input  logic                       i_result_ready,
   output logic [COUNT_W-1:0]         o_result_count,
   output logic                       o_err_short,
   output logic                       o_err_timeout
);
   localparam int COL_W = $clog2(IMG_COL);
   localparam int ROW_W = $clog2(IMG_ROW);
   localparam int TO_W  = $clog2(DONE_TIMEOUT + 1);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_COL - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_ROW - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(DONE_TIMEOUT - 1);
   localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(DONE_TIMEOUT);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT_SOF  = 3'd1;
   localparam logic [2:0] S_STREAM    = 3'd2;
   localparam logic [2:0] S_WAIT_DONE = 3'd3;
   localparam logic [2:0] S_RESULT    = 3'd4;

   logic [2:0]       state;
   logic [COL_W-1:0] col_cnt;
   logic [ROW_W-1:0] row_cnt;
   logic [TO_W-1:0]  to_cnt;

   logic             in_stream;
   logic             in_wait_sof;
   logic             last_pix;
   logic             restart;
   logic             accept;
   logic [COL_W-1:0] pix_col;
   logic [ROW_W-1:0] pix_row;

   // An SOF that arrives with the final pixel closes the frame instead of restarting it.
   always_comb begin
      in_stream   = (state == S_STREAM);
      in_wait_sof = (state == S_WAIT_SOF);
      last_pix    = in_stream & i_pix_valid & (col_cnt == COL_LAST) & (row_cnt == ROW_LAST);
      restart     = i_frame_start & (in_wait_sof | (in_stream & ~last_pix));
      accept      = i_pix_valid & (in_stream | (in_wait_sof & i_frame_start));
      pix_col     = restart ? '0 : col_cnt;
      pix_row     = restart ? '0 : row_cnt;
   end

   assign o_busy = (state != S_IDLE);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state          <= S_IDLE;
         col_cnt        <= '0;
         row_cnt        <= '0;
         to_cnt         <= '0;
         o_blob_valid   <= 1'b0;
         o_blob_seq     <= 1'b0;
         o_blob_clr     <= 1'b0;
         o_col          <= '0;
         o_row          <= '0;
         o_frame_last   <= 1'b0;
         o_result_valid <= 1'b0;
         o_result_count <= '0;
         o_err_short    <= 1'b0;
         o_err_timeout  <= 1'b0;
      end else begin
         o_blob_valid <= 1'b0;
         o_frame_last <= 1'b0;
         o_blob_clr   <= restart;

         if (accept) begin
            o_blob_valid <= 1'b1;
            o_blob_seq   <= i_pix_bin;
            o_col        <= pix_col;
            o_row        <= pix_row;
            o_frame_last <= last_pix;
            if (pix_col == COL_LAST) begin
               col_cnt <= '0;
               row_cnt <= (pix_row == ROW_LAST) ? '0 : pix_row + ROW_W'(1);
            end else begin
               col_cnt <= pix_col + COL_W'(1);
               row_cnt <= pix_row;
            end
         end else if (restart) begin
            col_cnt <= '0;
            row_cnt <= '0;
         end

         if (state == S_WAIT_DONE) begin
            if (to_cnt != TO_MAX) to_cnt <= to_cnt + TO_W'(1);
         end else begin
            to_cnt <= '0;
         end

         case (state)
            S_IDLE: begin
               if (i_start) begin
                  state         <= S_WAIT_SOF;
                  o_err_short   <= 1'b0;
                  o_err_timeout <= 1'b0;
               end
            end
            S_WAIT_SOF: begin
               if (i_frame_start) state <= S_STREAM;
            end
            S_STREAM: begin
               if (restart) o_err_short <= 1'b1;
               if (last_pix) state <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               // Completion takes priority over a timeout expiring in the same cycle.
               if (i_blob_done) begin
                  o_result_count <= i_blob_count;
                  o_result_valid <= 1'b1;
                  state          <= S_RESULT;
               end else if (to_cnt == TO_LAST) begin
                  o_result_count <= '0;
                  o_err_timeout  <= 1'b1;
                  o_result_valid <= 1'b1;
                  state          <= S_RESULT;
               end
            end
            S_RESULT: begin
               if (i_result_ready) begin
                  o_result_valid <= 1'b0;
                  state          <= i_continuous ? S_WAIT_SOF : S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
